// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer that shares one synchronous memory port between
// instruction fetch and data access, with a single transaction in flight.
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} stateT;
  typedef enum logic {OWN_IF, OWN_DATA} ownerT;

  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  stateT      state;
  stateT      nextState;
  ownerT      owner;
  ownerT      lastOwner;
  ownerT      grantOwner;
  logic       grant;
  logic [2:0] cnt;

  // Arbitration and next-state: on a tie the requester that did not own
  // the previous transaction wins.
  always_comb begin
    nextState  = state;
    grant      = 1'b0;
    grantOwner = OWN_IF;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant     = 1'b1;
          nextState = ACCESS;
          if (d_req && (!if_req || lastOwner == OWN_IF)) begin
            grantOwner = OWN_DATA;
          end
        end
      end
      ACCESS:  nextState = mem_we ? DONE : WAIT;
      WAIT:    if (cnt == 3'd0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The mem_* registers double as the latched request; they are loaded at
  // the grant edge so they are live only during the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lastOwner <= OWN_DATA;
      cnt       <= 3'd0;
      if_rdata  <= 32'd0;
      if_valid  <= 1'b0;
      d_rdata   <= 32'd0;
      d_valid   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      state     <= nextState;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner  <= grantOwner;
            mem_en <= 1'b1;
            if (grantOwner == OWN_DATA) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr <= if_addr;
            end
          end
        end
        ACCESS: begin
          if (mem_we) begin
            if (owner == OWN_DATA) d_valid <= 1'b1;
            else                   if_valid <= 1'b1;
          end else begin
            cnt <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else if (owner == OWN_DATA) begin
            d_rdata <= mem_rdata;
            d_valid <= 1'b1;
          end else begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end
        end
        DONE:    lastOwner <= owner;
        default: ;
      endcase
    end
  end

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

endmodule
